button_events: RTL and testbench

// - Consumes the debounced button level from debounce (button_pressed) and turns it into
//   one-cycle event pulses: press, release, click, double-click, long-press, auto-repeat.
// - Sits between debounce and the game/UI control FSMs. Those FSMs only ever see pulses,

---
 rtl/button_events_pkg.sv | 10 +
 rtl/button_events.sv | 103 ++++++++++
 tb/tb_button_events.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/button_events_pkg.sv
// button_events_pkg: state encoding and counter sizing shared by button_events.
package button_events_pkg;
  typedef enum logic [2:0] {WAIT_REL, IDLE, PRESS1, GAP, PRESS2, HELD} btn_state_t;
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction
endpackage

// File: rtl/button_events.sv
// button_events: turns a debounced button level into press/release/click/double/long/repeat pulses.
module button_events
  import button_events_pkg::*;
#(
  parameter logic PRESSED_LEVEL     = 1'b0,
  parameter int   LONG_COUNTS       = 50_000_000,
  parameter int   REPEAT_COUNTS     = 10_000_000,
  parameter int   DOUBLE_GAP_COUNTS = 15_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic click_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);
  localparam int CW = cnt_width(LONG_COUNTS, REPEAT_COUNTS, DOUBLE_GAP_COUNTS);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_COUNTS - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(DOUBLE_GAP_COUNTS - 1);
  localparam logic [CW-1:0] REP_LAST  = (REPEAT_COUNTS == 0) ? '0 : CW'(REPEAT_COUNTS - 1);
  btn_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic          w_pressed;
  logic [CW-1:0] w_cnt_inc;
  assign w_pressed = level == PRESSED_LEVEL;
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CW'(1);
  assign held      = r_state == HELD;
  // counter is cleared on every transition so each state times from its own entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= WAIT_REL;
      r_cnt         <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click_pulse   <= 1'b0;
      double_pulse  <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click_pulse   <= 1'b0;
      double_pulse  <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      r_cnt         <= w_cnt_inc;
      case (r_state)
        WAIT_REL: begin
          r_cnt <= '0;
          if (!w_pressed) r_state <= IDLE;
        end
        IDLE: begin
          r_cnt <= '0;
          if (w_pressed) begin
            r_state     <= PRESS1;
            press_pulse <= 1'b1;
          end
        end
        PRESS1, PRESS2: begin
          if (!w_pressed) begin
            r_state       <= (r_state == PRESS1) ? GAP : IDLE;
            r_cnt         <= '0;
            release_pulse <= 1'b1;
          end else if (r_cnt == LONG_LAST) begin
            r_state    <= HELD;
            r_cnt      <= '0;
            long_pulse <= 1'b1;
          end
        end
        GAP: begin
          if (w_pressed) begin
            r_state      <= PRESS2;
            r_cnt        <= '0;
            press_pulse  <= 1'b1;
            double_pulse <= 1'b1;
          end else if (r_cnt == GAP_LAST) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            click_pulse <= 1'b1;
          end
        end
        HELD: begin
          if (!w_pressed) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            release_pulse <= 1'b1;
          end else if (REPEAT_COUNTS != 0 && r_cnt == REP_LAST) begin
            r_cnt        <= '0;
            repeat_pulse <= 1'b1;
          end
        end
        default: begin
          r_state <= WAIT_REL;
          r_cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_button_events.sv
// tb_button_events: timestamp-based reference model, per-cycle compare, directed and random stimulus.
module tb_button_events;
  localparam int L = 8, R = 4, G = 5;
  logic clk = 1'b0, rst_n = 1'b0, level = 1'b1;
  logic press_pulse, release_pulse, click_pulse, double_pulse, long_pulse, repeat_pulse, held;
  logic [6:0] dut_v, exp_v = '0;
  int vectors = 0, errs = 0, cyc = 0;
  int n_press, n_rel, n_click, n_dbl, n_long, n_rep;
  int p_cyc, r_cyc, c_cyc, d_cyc, l_cyc, rep1_cyc, rep_cyc;
  int n = 0, t_press = 0, t_rel = 0;
  bit armed = 0, down = 0, second = 0, long_done = 0, gap_open = 0;

  button_events #(
    .PRESSED_LEVEL(1'b1), .LONG_COUNTS(L), .REPEAT_COUNTS(R), .DOUBLE_GAP_COUNTS(G)
  ) dut (
    .clk(clk), .rst_n(rst_n), .level(level), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .click_pulse(click_pulse), .double_pulse(double_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse), .held(held)
  );

  always #5 clk = ~clk;
  assign dut_v = {press_pulse, release_pulse, click_pulse, double_pulse, long_pulse, repeat_pulse, held};

  // model: events derived from press/release timestamps rather than a state machine
  always @(posedge clk) begin : model
    bit p, mp, mr, mc, md, ml, mrep;
    p = level;
    {mp, mr, mc, md, ml, mrep} = '0;
    n++;
    if (!rst_n) begin
      armed = 0; down = 0; gap_open = 0; long_done = 0;
    end else if (!armed) armed = !p;
    else if (down) begin
      if (!p) begin
        mr = 1; down = 0;
        if (!long_done && !second) begin gap_open = 1; t_rel = n; end
      end else if (!long_done && n - t_press == L) begin
        ml = 1; long_done = 1;
      end else if (long_done && (n - t_press - L) % R == 0) mrep = 1;
    end else if (p) begin
      mp = 1; md = gap_open; second = gap_open; gap_open = 0;
      down = 1; t_press = n; long_done = 0;
    end else if (gap_open && n - t_rel == G) begin
      mc = 1; gap_open = 0;
    end
    exp_v = {mp, mr, mc, md, ml, mrep, down && long_done};
  end

  always @(negedge clk) begin
    cyc++;
    vectors++;
    if (dut_v !== exp_v) begin
      errs++;
      $display("FAIL cycle %0d outputs {press,rel,click,dbl,long,rep,held}: got %b want %b", cyc, dut_v, exp_v);
    end
    if (press_pulse)   begin n_press++; p_cyc = cyc; end
    if (release_pulse) begin n_rel++;   r_cyc = cyc; end
    if (click_pulse)   begin n_click++; c_cyc = cyc; end
    if (double_pulse)  begin n_dbl++;   d_cyc = cyc; end
    if (long_pulse)    begin n_long++;  l_cyc = cyc; end
    if (repeat_pulse)  begin
      if (n_rep == 0) rep1_cyc = cyc;
      n_rep++; rep_cyc = cyc;
    end
  end

  task automatic step(input int k);
    repeat (k) begin @(negedge clk); #1; end
  endtask

  task automatic clear();
    {n_press, n_rel, n_click, n_dbl, n_long, n_rep} = '0;
    {p_cyc, r_cyc, c_cyc, d_cyc, l_cyc, rep1_cyc, rep_cyc} = '0;
  endtask

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  initial begin
    clear();
    step(2);
    check("reset_outputs", int'(dut_v), 0);
    rst_n = 1; clear();
    step(3);
    check("held_through_reset_press", n_press, 0);
    level = 0; step(2); level = 1; step(2);
    check("repress_press", n_press, 1);
    check("repress_release", n_rel, 0);
    level = 0; step(10);

    clear(); level = 1; step(3); level = 0; step(8);
    check("click_press", n_press, 1);
    check("click_release", n_rel, 1);
    check("click_count", n_click, 1);
    check("click_delay", c_cyc - r_cyc, G);
    check("click_no_double", n_dbl, 0);
    check("click_no_long", n_long, 0);

    clear(); level = 1; step(2); level = 0; step(2); level = 1; step(2); level = 0; step(8);
    check("dbl_press", n_press, 2);
    check("dbl_count", n_dbl, 1);
    check("dbl_with_press", d_cyc, p_cyc);
    check("dbl_release", n_rel, 2);
    check("dbl_no_click", n_click, 0);

    clear(); level = 1; step(20);
    check("long_delay", l_cyc - p_cyc, L);
    check("repeat_count", n_rep, 2);
    check("repeat1_delay", rep1_cyc - p_cyc, L + R);
    check("repeat2_delay", rep_cyc - p_cyc, L + 2 * R);
    check("held_level", int'(held), 1);
    level = 0; step(8);
    check("long_release", n_rel, 1);
    check("long_no_click", n_click, 0);

    clear(); level = 1; step(1); level = 0; step(5); level = 1; step(2);
    check("edge_double", n_dbl, 1);
    check("edge_double_gap", d_cyc - r_cyc, G);
    level = 0; step(8);
    check("edge_no_click", n_click, 0);

    clear(); level = 1; step(10);
    check("pre_reset_held", int'(held), 1);
    rst_n = 0; step(1);
    check("mid_reset_outputs", int'(dut_v), 0);
    rst_n = 1; clear(); step(5);
    check("post_reset_no_press", n_press, 0);
    check("post_reset_no_long", n_long + n_rep, 0);
    level = 0; step(2); level = 1; step(2);
    check("post_reset_fresh_press", n_press, 1);
    level = 0; step(10);

    repeat (300) begin
      if ($urandom_range(0, 40) == 0) begin rst_n = 0; step(1); rst_n = 1; end
      level = 1'($urandom_range(0, 1));
      step($urandom_range(1, 22));
    end
    level = 0; step(10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
